// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and constants for the serial pattern-scan controller.
package seq_scan_ctrl_pkg;

    localparam int BYTE_BITS = 8;
    localparam int PAT_MAX   = 4;
    localparam int PAT_MIN   = 2;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len < 3'(PAT_MIN)) begin
            return 3'(PAT_MIN);
        end
        if (len > 3'(PAT_MAX)) begin
            return 3'(PAT_MAX);
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_scan_if.sv
// Control, byte-stream and status signals of the scan controller.
interface seq_scan_if;
    import seq_scan_ctrl_pkg::*;

    logic             start;
    logic [3:0]       pat;
    logic [2:0]       pat_len;
    logic [3:0]       frame_len;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    modport master (
        output start, pat, pat_len, frame_len, data_in, data_valid,
        input  data_ready, match, match_cnt, busy, done
    );

    modport slave (
        input  start, pat, pat_len, frame_len, data_in, data_valid,
        output data_ready, match, match_cnt, busy, done
    );

endinterface

// File: rtl/seq_scan_ctrl_detector.sv
// Moore overlapping pattern detector; match is registered one cycle after the completing bit.
module seq_detector
    import seq_scan_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               bit_en,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pat,
    input  logic [2:0]         pat_len,
    output logic               match
);

    logic [PAT_MAX-1:0] hist_q, hist_d, mask;
    logic [2:0]         vcnt_q, vcnt_d;
    logic               match_q, match_d;

    always_comb begin
        mask    = '0;
        hist_d  = hist_q;
        vcnt_d  = vcnt_q;
        match_d = 1'b0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(pat_len)) begin
                mask[i] = 1'b1;
            end
        end
        if (bit_en) begin
            // Newest bit lands in hist[0], matching pat[0] as the last bit in time.
            hist_d = {hist_q[PAT_MAX-2:0], bit_in};
            if (vcnt_q < 3'(PAT_MAX)) begin
                vcnt_d = vcnt_q + 3'd1;
            end
            match_d = (vcnt_d >= pat_len) && ((hist_d & mask) == (pat & mask));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            vcnt_q  <= '0;
            match_q <= 1'b0;
        end else if (clr) begin
            hist_q  <= '0;
            vcnt_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            vcnt_q  <= vcnt_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts bytes, serialises them MSB first into the detector, counts matches.
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    seq_scan_if.slave bus
);

    state_e           state_q, state_d;
    logic [3:0]       pat_q;
    logic [2:0]       len_q;
    logic [3:0]       flen_q;
    logic [7:0]       sh_q;
    logic [2:0]       bit_cnt_q;
    logic [3:0]       byte_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_acc, load_xfer, bit_en, last_bit, last_byte, det_match;

    assign start_acc = (state_q == StIdle) && bus.start;
    assign last_bit  = (bit_cnt_q == 3'(BYTE_BITS - 1));
    // frame_len of 0 wraps to 15 here, giving a 16-byte frame.
    assign last_byte = (byte_idx_q == (flen_q - 4'd1));

    always_comb begin
        state_d   = state_q;
        load_xfer = 1'b0;
        bit_en    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (bus.data_valid) begin
                    load_xfer = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                bit_en = 1'b1;
                if (last_bit) begin
                    state_d = last_byte ? StDone : StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q      <= '0;
            len_q      <= 3'(PAT_MIN);
            flen_q     <= '0;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
        end else if (start_acc) begin
            pat_q      <= bus.pat;
            len_q      <= clamp_len(bus.pat_len);
            flen_q     <= bus.frame_len;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
        end else if (load_xfer) begin
            sh_q      <= bus.data_in;
            bit_cnt_q <= '0;
        end else if (bit_en) begin
            sh_q      <= {sh_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
                byte_idx_q <= byte_idx_q + 4'd1;
            end
        end
    end

    // cnt_q trails the live match pulse by one cycle; the output adds the pulse back in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (det_match) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    seq_detector u_det (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_acc),
        .bit_en  (bit_en),
        .bit_in  (sh_q[7]),
        .pat     (pat_q),
        .pat_len (len_q),
        .match   (det_match)
    );

    assign bus.data_ready = (state_q == StLoad);
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.match      = det_match;
    assign bus.match_cnt  = cnt_q + CNT_W'(det_match);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl.
module tb_seq_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    seq_scan_if bus ();

    seq_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [3:0] p, input logic [2:0] pl, input logic [3:0] fl);
        bus.pat       = p;
        bus.pat_len   = pl;
        bus.frame_len = fl;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", 8'(bus.busy), 8'd1);
        chk("start_ready", 8'(bus.data_ready), 8'd1);
        chk("start_cnt", bus.match_cnt, 8'd0);
    endtask

    // mask[k-1] = expected match in the cycle after bit k; start_at pulses start during bit k.
    task automatic send_byte(input logic [7:0] data, input logic [7:0] mask,
                             input logic [7:0] cnt0, input int start_at);
        logic [7:0] cnt;
        cnt          = cnt0;
        bus.data_in  = data;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) begin
                chk("shift_ready", 8'(bus.data_ready), 8'd0);
                chk("shift_busy", 8'(bus.busy), 8'd1);
            end
            if (k == start_at) begin
                bus.start = 1'b1;
                bus.frame_len = 4'd9;
            end
            tick();
            bus.start = 1'b0;
            if (mask[k-1]) begin
                cnt = cnt + 8'd1;
            end
            chk($sformatf("match_b%0d", k), 8'(bus.match), 8'(mask[k-1]));
            chk($sformatf("cnt_b%0d", k), bus.match_cnt, cnt);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.pat        = '0;
        bus.pat_len    = '0;
        bus.frame_len  = '0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        tick();
        tick();
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_ready", 8'(bus.data_ready), 8'd0);
        chk("rst_done", 8'(bus.done), 8'd0);
        chk("rst_match", 8'(bus.match), 8'd0);
        chk("rst_cnt", bus.match_cnt, 8'd0);
        rst = 1'b0;

        // 101 over 0xAA: matches after bits 3, 5, 7.
        start_frame(4'b0101, 3'd3, 4'd1);
        send_byte(8'hAA, 8'h54, 8'd0, 0);
        chk("aa_done", 8'(bus.done), 8'd1);
        chk("aa_cnt_done", bus.match_cnt, 8'd3);
        tick();
        chk("aa_done_pulse", 8'(bus.done), 8'd0);
        chk("aa_idle_busy", 8'(bus.busy), 8'd0);
        chk("aa_cnt_hold", bus.match_cnt, 8'd3);

        // Match across byte boundary, with an ignored start mid-shift.
        start_frame(4'b0101, 3'd3, 4'd2);
        send_byte(8'h01, 8'h00, 8'd0, 3);
        chk("xb_mid_ready", 8'(bus.data_ready), 8'd1);
        chk("xb_mid_done", 8'(bus.done), 8'd0);
        send_byte(8'h40, 8'h02, 8'd0, 0);
        chk("xb_done", 8'(bus.done), 8'd1);
        chk("xb_cnt", bus.match_cnt, 8'd1);
        tick();
        chk("xb_one_done", 8'(bus.done), 8'd0);
        chk("xb_idle", 8'(bus.busy), 8'd0);

        // Stall in LOAD, clamped pat_len, mid-frame input changes ignored.
        start_frame(4'b1111, 3'd7, 4'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", 8'(bus.data_ready), 8'd1);
            chk("stall_busy", 8'(bus.busy), 8'd1);
            chk("stall_match", 8'(bus.match), 8'd0);
        end
        bus.pat     = 4'b0000;
        bus.pat_len = 3'd2;
        send_byte(8'hFF, 8'hF8, 8'd0, 0);
        chk("ff_done", 8'(bus.done), 8'd1);
        chk("ff_cnt", bus.match_cnt, 8'd5);
        tick();

        // Asynchronous reset during bit 4, then immediate restart.
        start_frame(4'b0101, 3'd3, 4'd1);
        bus.data_in    = 8'hAA;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_match", 8'(bus.match), 8'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 8'(bus.busy), 8'd0);
        chk("arst_match", 8'(bus.match), 8'd0);
        chk("arst_cnt", bus.match_cnt, 8'd0);
        chk("arst_done", 8'(bus.done), 8'd0);
        chk("arst_ready", 8'(bus.data_ready), 8'd0);
        #1 rst = 1'b0;
        start_frame(4'b0101, 3'd3, 4'd1);
        send_byte(8'hAA, 8'h54, 8'd0, 0);
        chk("rerun_done", 8'(bus.done), 8'd1);
        chk("rerun_cnt", bus.match_cnt, 8'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
